// File: rtl/gcnt_pkg.sv
// Shared types and default constants for the Gray-code counter pulse generator.
package gcnt_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_DBNC   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_DBNC = 2'd3
    } t_pg_state;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_CYCLES   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; q is the second flop.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gcnt_pulse_gen.sv
// Debounced pushbutton to one-cycle advance pulse for a Gray-code counter.
// Optional auto-repeat while held is enabled by defining GCNT_AUTO_REPEAT_EN.
module gcnt_pulse_gen
    import gcnt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       gcnt,
    output logic       btn_state,
    output logic [7:0] press_cnt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DBC_LAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_dbc
        $error("gcnt_pulse_gen: DEBOUNCE_CYCLES out of range");
    end
    if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_rpt
        $error("gcnt_pulse_gen: REPEAT_CYCLES out of range");
    end

    logic            btn_sync;
    t_pg_state       state, state_n;
    logic [DW-1:0]   dbc, dbc_n;
    logic            press_fire;
    logic            pulse;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    always_comb begin
        state_n    = state;
        dbc_n      = dbc;
        press_fire = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_n = PRESS_DBNC;
                    dbc_n   = '0;
                end
            end
            PRESS_DBNC: begin
                if (!btn_sync) begin
                    state_n = IDLE;
                end else if (dbc == DBC_LAST) begin
                    state_n    = PRESSED;
                    press_fire = 1'b1;
                end else begin
                    dbc_n = dbc + DW'(1);
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_n = RELEASE_DBNC;
                    dbc_n   = '0;
                end
            end
            RELEASE_DBNC: begin
                // A glitch back to 1 resumes PRESSED silently: no new press.
                if (btn_sync) begin
                    state_n = PRESSED;
                end else if (dbc == DBC_LAST) begin
                    state_n = IDLE;
                end else begin
                    dbc_n = dbc + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef GCNT_AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt, rpt_n;
    logic          rpt_fire;

    // Held outside PRESSED, so a release glitch restarts the period from 0.
    always_comb begin
        rpt_n    = '0;
        rpt_fire = 1'b0;
        if (state == PRESSED) begin
            if (rpt == RPT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_n = rpt + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rpt <= '0;
        else     rpt <= rpt_n;
    end

    assign pulse = press_fire | rpt_fire;
`else
    assign pulse = press_fire;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dbc       <= '0;
            gcnt      <= 1'b0;
            btn_state <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            dbc       <= dbc_n;
            gcnt      <= pulse;
            btn_state <= (state_n == PRESSED) || (state_n == RELEASE_DBNC);
            if (pulse) press_cnt <= press_cnt + 8'd1;
        end
    end

endmodule
